// File: rtl/comb_sweep_checker.sv
// Exhaustive sweep engine for a single-output combinational DUT: drives every
// N-bit input vector, holds it SETTLE cycles, and checks the output against EXPECT.
module comb_sweep_checker #(
  parameter int              N      = 3,
  parameter int              SETTLE = 1,
  parameter logic [2**N-1:0] EXPECT = 8'hE8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic         dut_out,
  output logic [N-1:0] dut_in,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_cnt,
  output logic         first_err_valid,
  output logic [N-1:0] first_err_idx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_e       state_q, state_d;
  logic [N-1:0] dut_in_q, dut_in_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [N:0]   err_cnt_q, err_cnt_d;
  logic         first_err_valid_q, first_err_valid_d;
  logic [N-1:0] first_err_idx_q, first_err_idx_d;
  logic         pass_q, pass_d;

  logic sample;
  logic last_vec;
  logic mismatch;

  // The compare happens only on the final settle cycle of each vector.
  assign sample   = (state_q == RUN) && (cnt_q == SETTLE_LAST);
  assign last_vec = (dut_in_q == '1);
  assign mismatch = sample && (dut_out != EXPECT[dut_in_q]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      dut_in_q          <= '0;
      cnt_q             <= '0;
      err_cnt_q         <= '0;
      first_err_valid_q <= 1'b0;
      first_err_idx_q   <= '0;
      pass_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      dut_in_q          <= dut_in_d;
      cnt_q             <= cnt_d;
      err_cnt_q         <= err_cnt_d;
      first_err_valid_q <= first_err_valid_d;
      first_err_idx_q   <= first_err_idx_d;
      pass_q            <= pass_d;
    end
  end

  // abort outranks the final-vector exit; start is only honoured outside RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN: begin
        if (abort)                 state_d = IDLE;
        else if (sample && last_vec) state_d = DONE;
      end
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dut_in_d          = dut_in_q;
    cnt_d             = cnt_q;
    err_cnt_d         = err_cnt_q;
    first_err_valid_d = first_err_valid_q;
    first_err_idx_d   = first_err_idx_q;
    pass_d            = pass_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          dut_in_d          = '0;
          cnt_d             = '0;
          err_cnt_d         = '0;
          first_err_valid_d = 1'b0;
          first_err_idx_d   = '0;
          pass_d            = 1'b0;
        end
      end
      RUN: begin
        if (abort) begin
          dut_in_d = '0;
          cnt_d    = '0;
        end else if (sample) begin
          if (mismatch) begin
            err_cnt_d = err_cnt_q + (N+1)'(1);
            if (!first_err_valid_q) begin
              first_err_valid_d = 1'b1;
              first_err_idx_d   = dut_in_q;
            end
          end
          cnt_d = '0;
          if (last_vec) begin
            dut_in_d = '0;
            pass_d   = (err_cnt_d == '0);
          end else begin
            dut_in_d = dut_in_q + N'(1);
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        dut_in_d = '0;
        cnt_d    = '0;
      end
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  assign dut_in          = dut_in_q;
  assign pass            = pass_q;
  assign err_cnt         = err_cnt_q;
  assign first_err_valid = first_err_valid_q;
  assign first_err_idx   = first_err_idx_q;

endmodule

// File: doc/comb_sweep_checker.md
Name: comb_sweep_checker

Overview:
Synthesizable exhaustive stimulus-and-check engine for single-output combinational blocks. It is the parametrised successor of the 3-input bench sweep: N-bit input width, programmable settle time, and a truth table carried as a parameter. It adds a start/busy/done handshake, abort, a mismatch count and first-failure capture. It sits beside a combinational DUT: it drives the DUT inputs and samples the DUT output.

Parameters:
N, 3, DUT input width; legal 1..8.
SETTLE, 1, cycles each vector is held before the output is sampled; legal 1..15.
EXPECT, 8'hE8, 2**N-bit expected truth table; bit i is the expected output for input i (default is 3-input majority).

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a sweep; sampled in IDLE or DONE only.
abort  input  1  cancel a sweep in progress.
dut_out  input  1  DUT output under test.
dut_in  output  N  registered stimulus to the DUT.
busy  output  1  high while sweeping.
done  output  1  high in DONE until the next start.
pass  output  1  high in DONE when err_cnt == 0.
err_cnt  output  N+1  mismatches in the current/last sweep.
first_err_valid  output  1  at least one mismatch seen in this sweep.
first_err_idx  output  N  input vector of the first mismatch.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; dut_in, err_cnt and first_err_idx are 0; busy, done, pass and first_err_valid are 0. Reset mid-sweep discards all progress.
- States: IDLE, RUN, DONE (all registered; every output is a register or decodes directly from the state).
- IDLE or DONE with start=1: next cycle state=RUN, busy=1, done=0, pass=0, dut_in=0, settle counter=0, err_cnt=0, first_err_valid=0, first_err_idx=0.
- RUN:
  - dut_in holds each vector for exactly SETTLE cycles.
  - On the last cycle of a vector (counter==SETTLE-1), dut_out is sampled at the clock edge and compared with EXPECT[dut_in].
  - On a mismatch, err_cnt increments. If first_err_valid was 0, first_err_idx=dut_in and first_err_valid=1.
  - If dut_in != all-ones, dut_in increments and the counter clears.
  - If dut_in == all-ones, the next state is DONE. dut_in does not wrap. It returns to 0 when entering DONE.
- DONE: busy=0, done=1, pass=(err_cnt==0). Results hold until the next start.
- Timing: the sweep takes 2**N*SETTLE cycles. done rises on cycle 2**N*SETTLE+1 after the start-accept edge.
- Width: err_cnt is N+1 bits and reaches at most 2**N, so no saturation is needed.
- abort=1 in RUN: next state=IDLE, busy=0, done=0, dut_in=0. err_cnt and first_err_* keep their partial values. abort has priority over the final-vector transition.
- abort in IDLE or DONE is ignored.
- start while in RUN is ignored.
- start and abort together in RUN: abort wins.
- start and abort together in IDLE or DONE: start wins.

Test Plan:
- N=3, SETTLE=1, EXPECT=8'hE8, majority DUT model, pulse start -> dut_in steps 0..7 one per cycle; done=1 on cycle 9; pass=1; err_cnt=0; first_err_valid=0.
- Same setup with an inverted-majority DUT -> err_cnt=8, pass=0, first_err_valid=1, first_err_idx=0.
- Majority DUT with a fault forced only at input 5 -> err_cnt=1, first_err_idx=5, pass=0. Then restart with the fault removed -> err_cnt=0, pass=1, first_err_valid=0.
- SETTLE=3 -> each dut_in value held 3 cycles; done rises 25 cycles after the start-accept edge. A dut_out glitch on the first two cycles of a vector is not counted.
- Abort when dut_in=4, then separately drop rst_n mid-sweep:
  - abort -> IDLE next cycle, busy=0, done=0, dut_in=0, partial err_cnt held.
  - rst_n low -> all outputs 0 immediately, with no clock edge.
- Start pulsed during RUN -> no effect on the sequence. Then N=4, EXPECT=16'h6996 (xor4) with an xor DUT -> 16 vectors, err_cnt=0 (5-bit), pass=1.
